demo_top: RTL and testbench
===========================

// Module: demo_top
// PURPOSE
// - Self-contained demo of the shared system bus: two demo masters (D1, D2), one arbiter, two slave memories.
// - Each master issues one read or write per start pulse, using internally generated address and data.
// - Results are exposed as ready, read data and a compare flag.
// - Top-level block for board/bench bring-up of the bus.
// PARAMETERS
// - ADDR_WIDTH            16  full bus address width
// - DATA_WIDTH            8   bus data width
// - SLAVE_MEM_ADDR_WIDTH  12  per-slave offset width (4096 bytes per slave)
// - DEVICE_ADDR_WIDTH     ADDR_WIDTH-SLAVE_MEM_ADDR_WIDTH  device-select field, addr[15:12]
// - SLAVE_LATENCY         2   cycles from address phase to slave ack (>=1)
// PORTS
// - clk       in   1   single clock, all logic on posedge
// - rstn      in   1   reset: asynchronous, active-high (asserted = 1)
// - start     in   1   launch request; rising edge is the event
// - d1_ready  out  1   D1 idle and accepting a start
// - d1_mode   in   1   D1 operation: 0 = read, 1 = write
// - d1_en     in   1   D1 participates in the next start
// - d2_ready  out  1   D2 idle
// - d2_mode   in   1   D2 operation: 0 = read, 1 = write
// - d2_en     in   1   D2 participates in the next start
// - d1_rdata  out  8   D1 last read data
// - d1_match  out  1   D1 last read equalled its last written data
// - d2_rdata  out  8   D2 last read data
// - d2_match  out  1   D2 last read equalled its last written data
// BEHAVIOUR
// - Reset (rstn=1, async):
//   - All FSMs go to IDLE; bus is granted to no master.
//   - dX_ready=1, dX_rdata=0, dX_match=0.
//   - Offsets reset to 0; data seeds reset to D1 0x10 and D2 0x80; the arbiter round-robin pointer resets to favour D1.
//   - Memory contents are not cleared.
//   - Reset mid-transaction aborts the transaction cleanly; no partial write is committed after reset.
// - start is registered and edge-detected. A rising edge launches master X only if dX_en=1 and dX_ready=1 in that cycle.
//   - Both masters may launch on the same edge.
//   - Edges while busy are ignored, not queued.
// - dX_mode is latched at launch; later changes have no effect.
// - Master FSM: IDLE -> REQ -> ADDR -> WAIT -> DONE -> IDLE.
//   - REQ: req high until grant.
//   - ADDR: one cycle driving addr/wdata/wr/valid.
//   - WAIT: until slave ack.
//   - DONE: one cycle updating state, then ready=1.
// - dX_ready is 0 from the cycle after the launch edge until DONE completes. Uncontested, ready stays low for exactly 4+SLAVE_LATENCY cycles.
// - Addresses:
//   - D1 targets device 0, D2 targets device 1; addr = {dev, offset}.
//   - Write: wdata = data counter.
//   - After an acked write: remember (offset, data); offset += 1, wrapping 4095 -> 0; data += 1, wrapping 0xFF -> 0x00.
//   - Read: address = last written offset (0 if none).
//   - On ack, rdata is captured into dX_rdata. dX_match = (rdata == last written data) if a prior write exists, else 0.
//   - Write leaves dX_rdata and dX_match unchanged.
// - Arbiter: grant is registered and given only when the bus is free.
//   - Simultaneous requests are resolved round-robin: the last-served master loses.
//   - Grant is held until that master's ack, then released in the same cycle as ack.
//   - At most one master drives the bus; ungranted bus signals are 0.
// - Decoder: addr[15:12] selects slave 0 or 1.
//   - Any other device value gets an ack after SLAVE_LATENCY with rdata=0xFF and no memory effect.
// - Slave: 4096x8 synchronous memory.
//   - Samples valid/addr/wdata/wr in ADDR; ack is a one-cycle pulse SLAVE_LATENCY cycles later.
//   - A write is committed at ack.
// STRUCTURE
// - Shared package bus_pkg:
//   - Width constants ADDR_WIDTH, DATA_WIDTH, SLAVE_MEM_ADDR_WIDTH.
//   - Device IDs DEV_D1=0, DEV_D2=1.
//   - Master FSM state enum.
// - Sub-module demo_master, instantiated twice (DEV_ID, DATA_SEED params).
// - Arbiter, decoder and two slave memories inline in demo_top.
// TESTING
// - Reset then idle: d1_ready=d2_ready=1, d1_match=d2_match=0, rdata=0.
// - D1 only:
//   - Stimulus: write, write, read (d1_en=1, d2_en=0).
//   - Writes: 0x10 @0x0000, then 0x11 @0x0001.
//   - Read @0x0001 -> d1_rdata=0x11, d1_match=1.
//   - ready low for 4+SLAVE_LATENCY cycles each time.
// - Both enabled, same start edge, mode=1:
//   - D1 granted first and writes 0x10 @0x0000; D2 follows and writes 0x80 @0x1000.
//   - d2_ready rises SLAVE_LATENCY+2 cycles after d1_ready.
// - Ten loops of write/write/read on both masters:
//   - match=1 after every read; no bus overlap (assert grant one-hot).
//   - Final D1 offset = 20, final D1 data = 0x24.
// - start edge while d1_ready=0 -> ignored; exactly one transaction completes.
// - Assert rstn during WAIT of a write:
//   - Outputs reset immediately; no memory change at that address.
//   - After release: read returns prior content, match=0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions: widths, device IDs, master FSM states, address-phase bundle.
// Everything on this bus is single-outstanding, so no flow-control types are needed.
package bus_pkg;
  localparam int ADDR_WIDTH           = 16;
  localparam int DATA_WIDTH           = 8;
  localparam int SLAVE_MEM_ADDR_WIDTH = 12;
  localparam int DEVICE_ADDR_WIDTH    = ADDR_WIDTH - SLAVE_MEM_ADDR_WIDTH;
  localparam int MEM_DEPTH            = 1 << SLAVE_MEM_ADDR_WIDTH;

  localparam logic [DEVICE_ADDR_WIDTH-1:0] DEV_D1 = DEVICE_ADDR_WIDTH'(0);
  localparam logic [DEVICE_ADDR_WIDTH-1:0] DEV_D2 = DEVICE_ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_WAIT,
    ST_DONE
  } mst_state_t;

  typedef struct packed {
    logic                  vld;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdat;
  } bus_req_t;
endpackage

// File: rtl/demo_master.sv
// Demo bus master: one read or write per launch, self-generated address/data.
// Latency 4+SLAVE_LATENCY cycles uncontested; stalls in REQ until granted, start edges ignored while busy.
module demo_master
  import bus_pkg::*;
#(
  parameter logic [DEVICE_ADDR_WIDTH-1:0] DEV_ID    = DEV_D1,
  parameter logic [DATA_WIDTH-1:0]        DATA_SEED = 8'h10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_evt,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  grant,
  input  logic                  ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  req,
  output bus_req_t              bus_req,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  match
);

  mst_state_t                      state;
  logic                            mode_q;
  logic                            has_wr;
  logic [SLAVE_MEM_ADDR_WIDTH-1:0] offset;
  logic [SLAVE_MEM_ADDR_WIDTH-1:0] last_off;
  logic [DATA_WIDTH-1:0]           data;
  logic [DATA_WIDTH-1:0]           last_dat;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state    <= ST_IDLE;
      ready    <= 1'b1;
      req      <= 1'b0;
      bus_req  <= '0;
      rdata    <= '0;
      match    <= 1'b0;
      mode_q   <= 1'b0;
      has_wr   <= 1'b0;
      offset   <= '0;
      last_off <= '0;
      data     <= DATA_SEED;
      last_dat <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_evt && en && ready) begin
            mode_q <= mode;
            req    <= 1'b1;
            ready  <= 1'b0;
            state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (grant) begin
            req          <= 1'b0;
            bus_req.vld  <= 1'b1;
            bus_req.wr   <= mode_q;
            // Reads target the most recent write so the result can be compared.
            bus_req.addr <= {DEV_ID, (mode_q ? offset : last_off)};
            bus_req.wdat <= mode_q ? data : '0;
            state        <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          bus_req <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ack) begin
            if (mode_q) begin
              last_off <= offset;
              last_dat <= data;
              has_wr   <= 1'b1;
              offset   <= offset + SLAVE_MEM_ADDR_WIDTH'(1);
              data     <= data + DATA_WIDTH'(1);
            end else begin
              rdata <= bus_rdata;
              match <= has_wr && (bus_rdata == last_dat);
            end
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/demo_top.sv
// Bus demo: two masters, round-robin arbiter, decoder and two 4 KiB slave memories.
// Slave ack SLAVE_LATENCY cycles after the address phase; losing master waits in REQ.
module demo_top
  import bus_pkg::*;
#(
  parameter int SLAVE_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  output logic                  d1_ready,
  input  logic                  d1_mode,
  input  logic                  d1_en,
  output logic                  d2_ready,
  input  logic                  d2_mode,
  input  logic                  d2_en,
  output logic [DATA_WIDTH-1:0] d1_rdata,
  output logic                  d1_match,
  output logic [DATA_WIDTH-1:0] d2_rdata,
  output logic                  d2_match
);

  localparam int CW = $clog2(SLAVE_LATENCY + 1);

  logic start_q1, start_q2, start_evt;
  logic [1:0] req, grant;
  logic last_d2;
  logic bus_ack;
  logic [DATA_WIDTH-1:0] bus_rdata;
  bus_req_t m1_bus, m2_bus, bus;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      start_q1 <= 1'b0;
      start_q2 <= 1'b0;
    end else begin
      start_q1 <= start;
      start_q2 <= start_q1;
    end
  end
  assign start_evt = start_q1 & ~start_q2;

  demo_master #(.DEV_ID(DEV_D1), .DATA_SEED(8'h10)) u_d1 (
    .clk(clk), .rstn(rstn), .start_evt(start_evt), .en(d1_en), .mode(d1_mode),
    .grant(grant[0]), .ack(bus_ack & grant[0]), .bus_rdata(bus_rdata),
    .req(req[0]), .bus_req(m1_bus), .ready(d1_ready), .rdata(d1_rdata), .match(d1_match)
  );

  demo_master #(.DEV_ID(DEV_D2), .DATA_SEED(8'h80)) u_d2 (
    .clk(clk), .rstn(rstn), .start_evt(start_evt), .en(d2_en), .mode(d2_mode),
    .grant(grant[1]), .ack(bus_ack & grant[1]), .bus_rdata(bus_rdata),
    .req(req[1]), .bus_req(m2_bus), .ready(d2_ready), .rdata(d2_rdata), .match(d2_match)
  );

  // Re-arbitrating on the ack edge lets a waiting master win without a dead cycle.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      grant   <= 2'b00;
      last_d2 <= 1'b1;
    end else if (grant == 2'b00 || bus_ack) begin
      if (req[0] && (!req[1] || last_d2)) begin
        grant   <= 2'b01;
        last_d2 <= 1'b0;
      end else if (req[1]) begin
        grant   <= 2'b10;
        last_d2 <= 1'b1;
      end else begin
        grant <= 2'b00;
      end
    end
  end

  always_comb begin
    bus = '0;
    if (grant[0]) bus = m1_bus;
    else if (grant[1]) bus = m2_bus;
  end

  logic [DEVICE_ADDR_WIDTH-1:0]    dev;
  logic [SLAVE_MEM_ADDR_WIDTH-1:0] off;
  assign dev = bus.addr[ADDR_WIDTH-1 -: DEVICE_ADDR_WIDTH];
  assign off = bus.addr[SLAVE_MEM_ADDR_WIDTH-1:0];

  logic                            t_act, t_wr;
  logic [DEVICE_ADDR_WIDTH-1:0]    t_dev;
  logic [SLAVE_MEM_ADDR_WIDTH-1:0] t_off;
  logic [DATA_WIDTH-1:0]           t_wdat;
  logic [CW-1:0]                   t_cnt;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      t_act  <= 1'b0;
      t_wr   <= 1'b0;
      t_dev  <= '0;
      t_off  <= '0;
      t_wdat <= '0;
      t_cnt  <= '0;
    end else if (bus.vld) begin
      t_act  <= 1'b1;
      t_wr   <= bus.wr;
      t_dev  <= dev;
      t_off  <= off;
      t_wdat <= bus.wdat;
      t_cnt  <= CW'(SLAVE_LATENCY - 1);
    end else if (bus_ack) begin
      t_act <= 1'b0;
    end else if (t_act) begin
      t_cnt <= t_cnt - CW'(1);
    end
  end
  assign bus_ack = t_act && (t_cnt == '0);

  logic [DATA_WIDTH-1:0] mem0 [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem1 [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rd0, rd1;

  // Write commits only at ack, so a reset during the wait leaves memory untouched.
  always_ff @(posedge clk) begin
    if (bus.vld && dev == DEV_D1) rd0 <= mem0[off];
    if (bus_ack && t_wr && t_dev == DEV_D1) mem0[t_off] <= t_wdat;
  end

  always_ff @(posedge clk) begin
    if (bus.vld && dev == DEV_D2) rd1 <= mem1[off];
    if (bus_ack && t_wr && t_dev == DEV_D2) mem1[t_off] <= t_wdat;
  end

  always_comb begin
    bus_rdata = 8'hFF;
    if (t_dev == DEV_D1) bus_rdata = rd0;
    else if (t_dev == DEV_D2) bus_rdata = rd1;
  end

endmodule

// File: tb/tb_demo_top.sv
// Scoreboard bench for demo_top: expected results queued at launch, popped when ready rises.
module tb_demo_top;
  localparam int SL = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       start = 1'b0;
  logic       d1_mode = 1'b0, d1_en = 1'b0, d2_mode = 1'b0, d2_en = 1'b0;
  logic       d1_ready, d2_ready, d1_match, d2_match;
  logic [7:0] d1_rdata, d2_rdata;

  demo_top #(.SLAVE_LATENCY(SL)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .d1_ready(d1_ready), .d1_mode(d1_mode), .d1_en(d1_en),
    .d2_ready(d2_ready), .d2_mode(d2_mode), .d2_en(d2_en),
    .d1_rdata(d1_rdata), .d1_match(d1_match),
    .d2_rdata(d2_rdata), .d2_match(d2_match)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] rdata;
    logic       match;
    int         dur;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  // Reference model of both masters and the two memories.
  logic [7:0] mm [2][4096];
  int m_off[2], m_dat[2], m_loff[2], m_ldat[2], m_rd[2];
  bit m_has[2], m_mt[2];
  int last_served;

  int low_cnt[2], done_cnt[2], rise_cyc[2];
  bit prev_rdy[2];
  int cyc = 0;
  int overlaps = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_off[i]  = 0;
      m_dat[i]  = (i == 0) ? 'h10 : 'h80;
      m_loff[i] = 0;
      m_ldat[i] = 0;
      m_rd[i]   = 0;
      m_has[i]  = 0;
      m_mt[i]   = 0;
    end
    last_served = 1;
  endtask

  task automatic model_op(input int i, input bit wr, input int dur);
    exp_t e;
    if (wr) begin
      mm[i][m_off[i]] = 8'(m_dat[i]);
      m_loff[i] = m_off[i];
      m_ldat[i] = m_dat[i];
      m_has[i]  = 1;
      m_off[i]  = (m_off[i] + 1) % 4096;
      m_dat[i]  = (m_dat[i] + 1) % 256;
    end else begin
      m_rd[i] = int'(mm[i][m_loff[i]]);
      m_mt[i] = m_has[i] && (m_rd[i] == m_ldat[i]);
    end
    e.rdata = 8'(m_rd[i]);
    e.match = m_mt[i];
    e.dur   = dur;
    if (i == 0) q1.push_back(e);
    else q2.push_back(e);
  endtask

  task automatic observe(input int i, input logic rdy, input logic [7:0] rd, input logic mt);
    exp_t e;
    int   qs;
    if (!rdy) begin
      low_cnt[i]++;
    end else if (!prev_rdy[i]) begin
      done_cnt[i]++;
      rise_cyc[i] = cyc;
      qs = (i == 0) ? q1.size() : q2.size();
      check($sformatf("d%0d_sb_nonempty", i + 1), 32'(qs != 0), 32'(1));
      if (qs != 0) begin
        e = (i == 0) ? q1.pop_front() : q2.pop_front();
        check($sformatf("d%0d_rdata", i + 1), 32'(rd), 32'(e.rdata));
        check($sformatf("d%0d_match", i + 1), 32'(mt), 32'(e.match));
        if (e.dur != 0) check($sformatf("d%0d_ready_low_cycles", i + 1), 32'(low_cnt[i]), 32'(e.dur));
      end
      low_cnt[i] = 0;
    end
    prev_rdy[i] = rdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b1;
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    model_reset();
  endtask

  task automatic do_start(input bit e1, input bit m1, input bit e2, input bit m2, input bit track);
    bit l1, l2;
    int w1, w2;
    @(negedge clk);
    l1 = e1 && d1_ready;
    l2 = e2 && d2_ready;
    d1_en = e1; d1_mode = m1; d2_en = e2; d2_mode = m2;
    start = 1'b1;
    w1 = 4 + SL;
    w2 = 4 + SL;
    if (l1 && l2) begin
      if (last_served == 1) begin w2 = 6 + 2 * SL; last_served = 1; end
      else begin w1 = 6 + 2 * SL; last_served = 0; end
    end else if (l1) last_served = 0;
    else if (l2) last_served = 1;
    if (track) begin
      if (l1) model_op(0, m1, w1);
      if (l2) model_op(1, m2, w2);
    end
    repeat (2) @(negedge clk);
    start = 1'b0;
    d1_mode = ~m1;
    d2_mode = ~m2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(d1_ready && d2_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", 32'(n < 200), 32'(1));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int c0;
    prev_rdy[0] = 1; prev_rdy[1] = 1;
    model_reset();
    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (!$onehot0(dut.grant)) overlaps++;
        observe(0, d1_ready, d1_rdata, d1_match);
        observe(1, d2_ready, d2_rdata, d2_match);
      end
    join_none

    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    @(negedge clk);
    check("rst_d1_ready", 32'(d1_ready), 32'(1));
    check("rst_d2_ready", 32'(d2_ready), 32'(1));
    check("rst_d1_rdata", 32'(d1_rdata), 32'(0));
    check("rst_d2_rdata", 32'(d2_rdata), 32'(0));
    check("rst_d1_match", 32'(d1_match), 32'(0));
    check("rst_d2_match", 32'(d2_match), 32'(0));

    // D1 alone: write, write, read back the second write.
    do_start(1, 1, 0, 0, 1); wait_idle();
    do_start(1, 1, 0, 0, 1); wait_idle();
    do_start(1, 0, 0, 0, 1); wait_idle();
    check("d1only_rdata", 32'(d1_rdata), 32'(8'h11));
    check("d1only_match", 32'(d1_match), 32'(1));

    // Contended writes on one edge, then read both back.
    do_reset();
    do_start(1, 1, 1, 1, 1); wait_idle();
    check("d2_after_d1_rise_gap", 32'(rise_cyc[1] - rise_cyc[0]), 32'(SL + 2));
    do_start(1, 0, 1, 0, 1); wait_idle();
    check("both_d1_rdata", 32'(d1_rdata), 32'(8'h10));
    check("both_d2_rdata", 32'(d2_rdata), 32'(8'h80));
    check("both_d2_match", 32'(d2_match), 32'(1));

    // A second start edge while D1 is busy is dropped.
    do_reset();
    c0 = done_cnt[0];
    do_start(1, 1, 0, 0, 1);
    do_start(1, 1, 0, 0, 1);
    wait_idle();
    repeat (10) @(negedge clk);
    check("busy_edge_one_done", 32'(done_cnt[0] - c0), 32'(1));

    do_reset();
    for (int k = 0; k < 10; k++) begin
      do_start(1, 1, 1, 1, 1); wait_idle();
      do_start(1, 1, 1, 1, 1); wait_idle();
      do_start(1, 0, 1, 0, 1); wait_idle();
      check("loop_d1_match", 32'(d1_match), 32'(1));
      check("loop_d2_match", 32'(d2_match), 32'(1));
    end
    do_start(1, 1, 0, 0, 1); wait_idle();
    do_start(1, 0, 0, 0, 1); wait_idle();
    check("d1_data_after_loops", 32'(d1_rdata), 32'(8'h24));

    // Reset in the wait phase of a write aborts it.
    begin
      exp_t ab;
      ab.rdata = 8'h00; ab.match = 1'b0; ab.dur = 0;
      do_start(1, 1, 0, 0, 0);
      repeat (3) @(negedge clk);
      q1.push_back(ab);
      #2 rstn = 1'b1;
      #1;
      check("abort_d1_ready", 32'(d1_ready), 32'(1));
      check("abort_d1_rdata", 32'(d1_rdata), 32'(0));
      check("abort_d1_match", 32'(d1_match), 32'(0));
      repeat (2) @(negedge clk);
      #2 rstn = 1'b0;
      model_reset();
    end
    do_start(1, 0, 0, 0, 1); wait_idle();
    check("post_abort_rdata", 32'(d1_rdata), 32'(8'h10));
    check("post_abort_match", 32'(d1_match), 32'(0));

    check("grant_onehot_violations", 32'(overlaps), 32'(0));
    check("d1_sb_drained", 32'(q1.size()), 32'(0));
    check("d2_sb_drained", 32'(q2.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
